spi_master: RTL and testbench

- SPI mode-0 (CPOL=0, CPHA=0) bus master, MSB-first, 8-bit frames. It drives sclk, cs_n and mosi and samples miso.
- Runs entirely on the clk_sb fabric clock; sclk is derived by division, with no second clock domain.
- Connects a byte-stream source/sink (valid/ready) to an external SPI slave, including the team's own SPI slave on another board.
- Supports multi-byte transactions: cs_n stays low until a byte flagged tx_last has completed.

---
 rtl/spi_master.sv | 207 ++++++++++++++++++++
 tb/tb_spi_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 bus master (CPOL=0, CPHA=0), 8-bit frames, sclk divided from clk_sb.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting in both directions.
module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic       clk_sb,
  input  logic       reset_n,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       sclk_o,
  output logic       cs_n_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_NEXT,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] IDLE_LAST  = 8'(CS_IDLE - 1);

`ifdef SPI_MASTER_LSB_FIRST_EN
  function automatic logic first_bit(input logic [7:0] b);
    return b[0];
  endfunction

  function automatic logic [7:0] shift_tx(input logic [7:0] b);
    return {1'b0, b[7:1]};
  endfunction

  function automatic logic [7:0] shift_rx(input logic [7:0] r, input logic bit_in);
    return {bit_in, r[7:1]};
  endfunction
`else
  function automatic logic first_bit(input logic [7:0] b);
    return b[7];
  endfunction

  function automatic logic [7:0] shift_tx(input logic [7:0] b);
    return {b[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] shift_rx(input logic [7:0] r, input logic bit_in);
    return {r[6:0], bit_in};
  endfunction
`endif

  state_t     state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [3:0] bit_q, bit_d;
  logic       sclk_q, sclk_d;
  logic       cs_n_q, cs_n_d;
  logic       mosi_q, mosi_d;
  logic       last_q, last_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic       accept;

  assign tx_ready_o = (state_q == S_IDLE) || (state_q == S_NEXT);
  assign busy_o     = (state_q != S_IDLE);
  assign accept     = tx_valid_i && tx_ready_o;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q + 8'd1;
    bit_d      = bit_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    last_d     = last_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;

    case (state_q)
      S_IDLE: begin
        phase_d = phase_q;
        if (accept) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
          mosi_d  = first_bit(tx_data_i);
          tx_sr_d = tx_data_i;
          last_d  = tx_last_i;
        end
      end
      S_SETUP: begin
        if (phase_q == SETUP_LAST) begin
          state_d = S_HIGH;
          sclk_d  = 1'b1;
        end
      end
      S_HIGH: begin
        // miso is taken on the final high cycle, right before sclk falls.
        if (phase_q == DIV_LAST) begin
          sclk_d  = 1'b0;
          rx_sr_d = shift_rx(rx_sr_q, miso_i);
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd7) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_rx(rx_sr_q, miso_i);
            state_d    = last_q ? S_HOLD : S_NEXT;
          end else begin
            state_d = S_LOW;
            tx_sr_d = shift_tx(tx_sr_q);
            mosi_d  = first_bit(shift_tx(tx_sr_q));
          end
        end
      end
      S_LOW: begin
        if (phase_q == DIV_LAST) begin
          state_d = S_HIGH;
          sclk_d  = 1'b1;
        end
      end
      S_NEXT: begin
        phase_d = phase_q;
        if (accept) begin
          state_d = S_LOW;
          mosi_d  = first_bit(tx_data_i);
          tx_sr_d = tx_data_i;
          last_d  = tx_last_i;
        end
      end
      S_HOLD: begin
        if (phase_q == HOLD_LAST) begin
          state_d = S_GAP;
          cs_n_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (phase_q == IDLE_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
      end
    endcase

    // Phase restarts on every state change; bit count spans only the HIGH/LOW loop.
    if (state_d != state_q) begin
      phase_d = 8'd0;
      if ((state_d != S_HIGH) && (state_d != S_LOW)) begin
        bit_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      phase_q    <= 8'd0;
      bit_q      <= 4'd0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      last_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      last_q     <= last_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Shift registers are fully reloaded/refilled every byte, so they carry no reset.
  always_ff @(posedge clk_sb) begin
    tx_sr_q <= tx_sr_d;
    rx_sr_q <= rx_sr_d;
  end

  assign sclk_o     = sclk_q;
  assign cs_n_o     = cs_n_q;
  assign mosi_o     = mosi_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback and scripted-slave transfers, stalls,
// ignored tx_valid, mid-frame reset, and LSB-first when SPI_MASTER_LSB_FIRST_EN is set.
module tb_spi_master;

  logic       clk_sb = 1'b0;
  logic       reset_n = 1'b1;
  logic       tx_valid, tx_last, tx_ready, rx_valid, busy, sclk, cs_n, mosi, miso;
  logic [7:0] tx_data, rx_data;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_sb = ~clk_sb;

  spi_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)) dut (
    .clk_sb     (clk_sb),
    .reset_n    (reset_n),
    .tx_valid_i (tx_valid),
    .tx_data_i  (tx_data),
    .tx_last_i  (tx_last),
    .tx_ready_o (tx_ready),
    .rx_valid_o (rx_valid),
    .rx_data_o  (rx_data),
    .busy_o     (busy),
    .sclk_o     (sclk),
    .cs_n_o     (cs_n),
    .mosi_o     (mosi),
    .miso_i     (miso)
  );

  // Wire order of a byte: identity for MSB-first, bit-reversed for LSB-first.
  function automatic logic [7:0] bitord(input logic [7:0] b);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
`else
    return b;
`endif
  endfunction

  // Scripted MSB-first mode-0 slave, or plain loopback when slv_en is low.
  logic       slv_en = 1'b0;
  logic [7:0] slv_tab [0:3];
  logic [7:0] slv_sr = 8'h00;
  logic [1:0] slv_idx = 2'd0;
  logic [2:0] slv_cnt = 3'd0;
  assign miso = slv_en ? slv_sr[7] : mosi;

  logic        mon_clr = 1'b0;
  logic        cs_prev = 1'b1, sclk_prev = 1'b0;
  int          pulse_cnt, hi_run, lo_run, hi_min, hi_max, lo_min, lo_max;
  int          cs_low_run, cs_low_last, cs_rise, gap_run;
  logic [31:0] mosi_log;
  logic [7:0]  rxv_cnt;
  logic [7:0]  rx_log [0:3];

  always @(negedge clk_sb) begin
    cs_prev   <= cs_n;
    sclk_prev <= sclk;
    if (mon_clr) begin
      pulse_cnt <= 0; hi_run <= 0; lo_run <= 0;
      hi_min <= 255; hi_max <= 0; lo_min <= 255; lo_max <= 0;
      cs_low_run <= 0; cs_low_last <= 0; cs_rise <= 0; gap_run <= 0;
      mosi_log <= 32'h0; rxv_cnt <= 8'd0;
    end else begin
      if (sclk) hi_run <= hi_run + 1;
      if (!sclk && !cs_n && pulse_cnt > 0) lo_run <= lo_run + 1;
      if (!sclk_prev && sclk) begin
        pulse_cnt <= pulse_cnt + 1;
        mosi_log  <= {mosi_log[30:0], mosi};
        if (pulse_cnt > 0) begin
          if (lo_run < lo_min) lo_min <= lo_run;
          if (lo_run > lo_max) lo_max <= lo_run;
        end
        lo_run <= 0;
      end
      if (sclk_prev && !sclk) begin
        if (hi_run < hi_min) hi_min <= hi_run;
        if (hi_run > hi_max) hi_max <= hi_run;
        hi_run <= 0;
      end
      if (!cs_n) cs_low_run <= cs_low_run + 1;
      if (!cs_prev && cs_n) begin
        cs_rise     <= cs_rise + 1;
        cs_low_last <= cs_low_run;
        cs_low_run  <= 0;
      end
      if (cs_n && busy) gap_run <= gap_run + 1;
      if (rx_valid) begin
        rx_log[rxv_cnt[1:0]] <= rx_data;
        rxv_cnt <= rxv_cnt + 8'd1;
      end
    end
    if (cs_prev && !cs_n) begin
      slv_sr  <= slv_tab[0];
      slv_idx <= 2'd1;
      slv_cnt <= 3'd0;
    end else if (sclk_prev && !sclk) begin
      if (slv_cnt == 3'd7) begin
        slv_sr  <= slv_tab[slv_idx];
        slv_idx <= slv_idx + 2'd1;
        slv_cnt <= 3'd0;
      end else begin
        slv_sr  <= {slv_sr[6:0], 1'b0};
        slv_cnt <= slv_cnt + 3'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    @(posedge clk_sb);
    #1 mon_clr = 1'b1;
    @(negedge clk_sb);
    #1 mon_clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    @(negedge clk_sb);
    tx_valid = 1'b1; tx_data = d; tx_last = l;
    for (int n = 0; n < 2000; n++) begin
      if (tx_ready) begin ok = 1'b1; break; end
      @(negedge clk_sb);
    end
    if (ok) @(posedge clk_sb);
    #1 tx_valid = 1'b0;
    chk("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_sb);
      if (!busy) break;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int err;
    tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    slv_tab[0] = 8'h3C; slv_tab[1] = 8'hC3; slv_tab[2] = 8'h00; slv_tab[3] = 8'h00;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk_sb);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;

    // Single byte, loopback.
    clr_mon();
    send(8'hA5, 1'b1);
    wait_idle("t1_idle");
    chk("t1_pulses", pulse_cnt, 8);
    chk("t1_hi_min", hi_min, 4);
    chk("t1_hi_max", hi_max, 4);
    chk("t1_lo_min", lo_min, 4);
    chk("t1_lo_max", lo_max, 4);
    chk("t1_cs_low", cs_low_last, 64);
    chk("t1_cs_rise", cs_rise, 1);
    chk("t1_gap", gap_run, 2);
    chk("t1_rxv", {24'd0, rxv_cnt}, 32'd1);
    chk("t1_rx_data", {24'd0, rx_data}, 32'hA5);
    chk("t1_mosi_bits", {24'd0, mosi_log[7:0]}, {24'd0, bitord(8'hA5)});
    chk("t1_mosi_held", {31'd0, mosi}, 32'd1);

    // Three bytes against the scripted slave.
    clr_mon();
    slv_en = 1'b1;
    send(8'h01, 1'b0);
    send(8'h80, 1'b0);
    send(8'hFF, 1'b1);
    wait_idle("t2_idle");
    slv_en = 1'b0;
    chk("t2_pulses", pulse_cnt, 24);
    chk("t2_cs_rise", cs_rise, 1);
    chk("t2_rxv", {24'd0, rxv_cnt}, 32'd3);
    chk("t2_rx0", {24'd0, rx_log[0]}, {24'd0, bitord(8'h3C)});
    chk("t2_rx1", {24'd0, rx_log[1]}, {24'd0, bitord(8'hC3)});
    chk("t2_rx2", {24'd0, rx_log[2]}, {24'd0, bitord(8'h00)});
    chk("t2_mosi_bits", {8'd0, mosi_log[23:0]},
        {8'd0, bitord(8'h01), bitord(8'h80), bitord(8'hFF)});
    chk("t2_lo_min", lo_min, 4);
    chk("t2_lo_max", lo_max, 5);

    // Stall in NEXT for 20 cycles, then resume.
    clr_mon();
    send(8'h12, 1'b0);
    for (n = 0; n < 500; n++) begin
      @(negedge clk_sb);
      if (tx_ready && busy) break;
    end
    chk("t3_in_next", {31'd0, tx_ready && busy}, 32'd1);
    err = 0;
    repeat (20) begin
      @(negedge clk_sb);
      if (sclk || cs_n || !tx_ready) err++;
    end
    chk("t3_stall", err, 0);
    tx_valid = 1'b1; tx_data = 8'h34; tx_last = 1'b1;
    n = 0;
    do begin
      @(posedge clk_sb);
      #1;
      n++;
      if (n == 1) tx_valid = 1'b0;
    end while (!sclk && n < 50);
    chk("t3_resume_low", n, 5);
    wait_idle("t3_idle");
    chk("t3_rxv", {24'd0, rxv_cnt}, 32'd2);
    chk("t3_rx_data", {24'd0, rx_data}, 32'h34);
    chk("t3_mosi_bits", {16'd0, mosi_log[15:0]}, {16'd0, bitord(8'h12), bitord(8'h34)});

    // tx_valid with other data during HIGH/LOW must be ignored.
    clr_mon();
    send(8'h3C, 1'b1);
    @(negedge clk_sb);
    tx_valid = 1'b1; tx_data = 8'hFF; tx_last = 1'b0;
    err = 0;
    repeat (20) begin
      @(negedge clk_sb);
      if (tx_ready) err++;
    end
    tx_valid = 1'b0;
    chk("t4_not_ready", err, 0);
    wait_idle("t4_idle");
    repeat (5) @(negedge clk_sb);
    chk("t4_no_extra", {31'd0, busy}, 32'd0);
    chk("t4_pulses", pulse_cnt, 8);
    chk("t4_rx_data", {24'd0, rx_data}, 32'h3C);
    chk("t4_mosi_bits", {24'd0, mosi_log[7:0]}, {24'd0, bitord(8'h3C)});

    // Reset after the 4th sclk pulse.
    clr_mon();
    send(8'hA5, 1'b1);
    for (n = 0; n < 500; n++) begin
      @(negedge clk_sb);
      #1;
      if (pulse_cnt == 4 && !sclk) break;
    end
    chk("t5_reached_pulse4", pulse_cnt, 4);
    chk("t5_pre_cs_n", {31'd0, cs_n}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_async_cs_n", {31'd0, cs_n}, 32'd1);
    chk("t5_async_sclk", {31'd0, sclk}, 32'd0);
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk_sb);
    reset_n = 1'b1;
    chk("t5_no_rxv", {24'd0, rxv_cnt}, 32'd0);
    chk("t5_rx_data_cleared", {24'd0, rx_data}, 32'h00);
    clr_mon();
    send(8'h5A, 1'b1);
    wait_idle("t5_idle");
    chk("t5_pulses", pulse_cnt, 8);
    chk("t5_rxv", {24'd0, rxv_cnt}, 32'd1);
    chk("t5_rx_data", {24'd0, rx_data}, 32'h5A);

`ifdef SPI_MASTER_LSB_FIRST_EN
    // LSB-first: 0x01 puts mosi high on the first pulse only.
    clr_mon();
    send(8'h01, 1'b1);
    wait_idle("t6_idle");
    chk("t6_mosi_bits", {24'd0, mosi_log[7:0]}, 32'h80);
    chk("t6_rx_data", {24'd0, rx_data}, 32'h01);
    chk("t6_pulses", pulse_cnt, 8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
